// File: rtl/im_boot_loader.sv
// rtl/im_boot_loader.sv - byte-stream loader for the core's instruction memory
// Holds the core in reset until a counted, checksummed load has been written to IM.
module im_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0]     CAP = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [7:0]        r_cnt_hi;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   r_word_idx;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_shift;
    logic [7:0]        r_csum;
    logic              r_in_ready;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_words_loaded;

    logic              w_accept;
    logic [15:0]       w_full_cnt;
    logic              w_last_word;

    assign w_accept    = in_valid & r_in_ready;
    assign w_full_cnt  = {r_cnt_hi, in_data};
    assign w_last_word = (r_word_idx == (r_cnt - ONE));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_CNT_HI;
            r_cnt_hi       <= '0;
            r_cnt          <= '0;
            r_word_idx     <= '0;
            r_byte_idx     <= '0;
            r_shift        <= '0;
            r_csum         <= '0;
            r_in_ready     <= 1'b0;
            r_im_we        <= 1'b0;
            r_im_addr      <= '0;
            r_im_wdata     <= '0;
            r_cpu_rst      <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_words_loaded <= '0;
        end else begin
            r_im_we    <= 1'b0;
            r_in_ready <= (r_state != S_DONE) && (r_state != S_ERR);
            if (restart) begin
                // Any byte offered alongside restart is dropped on purpose.
                r_state        <= S_CNT_HI;
                r_done         <= 1'b0;
                r_err          <= 1'b0;
                r_cpu_rst      <= 1'b0;
                r_words_loaded <= '0;
                r_in_ready     <= 1'b1;
            end else begin
                case (r_state)
                    S_CNT_HI: begin
                        if (w_accept) begin
                            r_cnt_hi <= in_data;
                            r_state  <= S_CNT_LO;
                        end
                    end
                    S_CNT_LO: begin
                        if (w_accept) begin
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                            r_csum     <= '0;
                            if ({1'b0, w_full_cnt} > CAP) begin
                                r_state    <= S_ERR;
                                r_err      <= 1'b1;
                                r_in_ready <= 1'b0;
                            end else if (w_full_cnt == 16'd0) begin
                                r_state <= S_CSUM;
                            end else begin
                                r_cnt   <= w_full_cnt[ADDR_W:0];
                                r_state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_accept) begin
                            r_csum     <= r_csum ^ in_data;
                            r_shift    <= {r_shift[15:0], in_data};
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (r_byte_idx == 2'd3) begin
                                r_im_we        <= 1'b1;
                                r_im_addr      <= r_word_idx[ADDR_W-1:0];
                                r_im_wdata     <= {r_shift, in_data};
                                r_word_idx     <= r_word_idx + ONE;
                                r_words_loaded <= r_words_loaded + ONE;
                                if (w_last_word) begin
                                    r_state <= S_CSUM;
                                end
                            end
                        end
                    end
                    S_CSUM: begin
                        if (w_accept) begin
                            r_in_ready <= 1'b0;
                            if (in_data == r_csum) begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_cpu_rst <= 1'b1;
                            end else begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign im_we        = r_im_we;
    assign im_addr      = r_im_addr;
    assign im_wdata     = r_im_wdata;
    assign cpu_rst      = r_cpu_rst;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_im_boot_loader.sv
// tb/tb_im_boot_loader.sv - self-checking bench for im_boot_loader
module tb_im_boot_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              restart = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int errors = 0;
    int checks = 0;

    typedef logic [7:0]  bq_t[$];
    typedef logic [39:0] wq_t[$];

    wq_t got;
    bq_t s1;

    im_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .restart      (restart),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) got.push_back({im_addr, im_wdata});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    task automatic model(input bq_t s, output wq_t w, output bit d, output bit e, output int n);
        int cnt;
        logic [7:0] cs;
        logic [31:0] word;
        w = {};
        d = 1'b0;
        e = 1'b0;
        n = 0;
        cnt = {s[0], s[1]};
        if (cnt > (1 << ADDR_W)) begin
            e = 1'b1;
            return;
        end
        cs = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            word = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
            cs = cs ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
            w.push_back({8'(i), word});
        end
        n = cnt;
        if (s[2+4*cnt] == cs) d = 1'b1;
        else e = 1'b1;
    endtask

    function automatic bq_t make_stream(int cnt, bit bad);
        bq_t s;
        logic [7:0] cs;
        logic [7:0] b;
        s = {};
        cs = 8'h00;
        s.push_back(8'(cnt >> 8));
        s.push_back(8'(cnt));
        for (int i = 0; i < 4 * cnt; i++) begin
            b = 8'($urandom);
            s.push_back(b);
            cs = cs ^ b;
        end
        if (bad) cs = cs ^ 8'(1 << $urandom_range(7, 0));
        s.push_back(cs);
        return s;
    endfunction

    task automatic send_stream(input bq_t s, input int max_gap);
        int gap;
        int t;
        foreach (s[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[i];
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL stall byte %0d: in_ready=%b required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic restart_pulse(input bit with_byte);
        restart  = 1'b1;
        in_valid = with_byte;
        in_data  = 8'hFF;
        @(negedge clk);
        restart  = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({done, err, cpu_rst} !== 3'b000 || words_loaded !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_state: done=%b err=%b cpu_rst=%b words=%0d ready=%b required 0 0 0 0 1",
                     done, err, cpu_rst, words_loaded, in_ready);
        end
    endtask

    task automatic run_load(input string name, input bq_t s, input int max_gap);
        wq_t exp_w;
        bit  exp_d;
        bit  exp_e;
        int  exp_n;
        int  m;
        model(s, exp_w, exp_d, exp_e, exp_n);
        got = {};
        send_stream(s, max_gap);
        repeat (3) @(negedge clk);
        checks++;
        if (got.size() !== exp_w.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, got.size(), exp_w.size());
        end
        m = (got.size() < exp_w.size()) ? got.size() : exp_w.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL %s write[%0d]: got %h required %h", name, i, got[i], exp_w[i]);
            end
        end
        checks++;
        if (done !== exp_d || err !== exp_e || cpu_rst !== exp_d) begin
            errors++;
            $display("FAIL %s flags: done=%b err=%b cpu_rst=%b required %b %b %b",
                     name, done, err, cpu_rst, exp_d, exp_e, exp_d);
        end
        checks++;
        if (words_loaded !== (ADDR_W+1)'(exp_n)) begin
            errors++;
            $display("FAIL %s words_loaded: got %0d required %0d", name, words_loaded, exp_n);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s final_ready: got %b required 0", name, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, im_we, cpu_rst, done, err} !== 5'b0 || im_addr !== '0 ||
            im_wdata !== 32'h0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b we=%b addr=%h wdata=%h cpu_rst=%b done=%b err=%b words=%0d required all 0",
                     in_ready, im_we, im_addr, im_wdata, cpu_rst, done, err, words_loaded);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        run_load("basic", s1, 0);
        checks++;
        if (got.size() < 2 || got[0] !== {8'h00, 32'h20080005} || got[1] !== {8'h01, 32'h2009000A}) begin
            errors++;
            $display("FAIL basic_im_contents: got size %0d required IM[0]=20080005 IM[1]=2009000a", got.size());
        end
    endtask

    task automatic test_bad_csum();
        bq_t s;
        s = s1;
        s[s.size()-1] = 8'h0F;
        restart_pulse(1'b0);
        run_load("bad_csum", s, 0);
    endtask

    task automatic test_zero_and_cap();
        bq_t s;
        restart_pulse(1'b0);
        s = '{8'h00, 8'h00, 8'h00};
        run_load("zero_count", s, 0);
        restart_pulse(1'b0);
        s = '{8'h01, 8'h01};
        run_load("over_cap", s, 0);
        restart_pulse(1'b0);
        run_load("full_cap", make_stream(1 << ADDR_W, 1'b0), 0);
    endtask

    task automatic test_gaps();
        restart_pulse(1'b0);
        run_load("gaps", s1, 5);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            restart_pulse(1'b0);
            run_load("random", make_stream(int'($urandom_range(12, 1)), $urandom_range(3, 0) == 0), 3);
        end
    endtask

    task automatic test_restart();
        bq_t s;
        restart_pulse(1'b0);
        s = '{8'h00, 8'h02, 8'h20, 8'h08};
        send_stream(s, 0);
        restart_pulse(1'b1);
        run_load("restart", s1, 0);
    endtask

    task automatic test_mid_reset();
        bq_t s;
        restart_pulse(1'b0);
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20};
        send_stream(s, 0);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, im_we, cpu_rst, done, err} !== 5'b0 || im_addr !== '0 ||
            im_wdata !== 32'h0 || words_loaded !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: ready=%b we=%b addr=%h wdata=%h words=%0d required all 0",
                     in_ready, im_we, im_addr, im_wdata, words_loaded);
        end
        rst = 1'b1;
        @(negedge clk);
        run_load("after_reset", s1, 0);
    endtask

    initial begin
        s1 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
        @(negedge clk);
        test_reset();
        test_basic();
        test_bad_csum();
        test_zero_and_cap();
        test_gaps();
        test_random();
        test_restart();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
